dmem_subword_np: RTL and testbench

Parametrised, banked data memory with native sub-word access, and the next generation of the core's load/store backing store. It provides NRP synchronous read ports and NWP write ports. Byte-lane write enables replace read-modify-write of the stored word. Loads return aligned, optionally sign-extended data with a valid strobe. Misaligned accesses are flagged rather than silently corrupting memory. It sits between the LSU / store buffer and main RAM.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_load_align.sv | 110 +++++++++++
 rtl/dmem_subword_np.sv | 124 ++++++++++++
 tb/tb_dmem_subword_np.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared size encodings and lane/alignment helpers for the sub-word data memory.
package dmem_pkg;

  localparam logic [1:0] SIZE_REQ_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_REQ_HALF  = 2'd1;
  localparam logic [1:0] SIZE_REQ_WORD  = 2'd2;
  localparam logic [1:0] SIZE_REQ_DWORD = 2'd3;

  // Byte lanes touched by an access of 2**size bytes starting at lane `offset`.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [15:0] m;
    m = (16'd1 << (5'd1 << size)) - 16'd1;
    m = m << offset;
    return m[7:0];
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] offset);
    logic ok;
    unique case (size)
      SIZE_REQ_BYTE:  ok = 1'b1;
      SIZE_REQ_HALF:  ok = (offset[0] == 1'b0);
      SIZE_REQ_WORD:  ok = (offset[1:0] == 2'b00);
      default:        ok = (offset == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Per-read-port load stage: captures the request controls, then shifts, truncates
// and sign/zero-extends the word returned by the banks.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int OUT_REG  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic [2:0]          offset,
  input  logic [1:0]          size,
  input  logic                sgn,
  input  logic                fault,
  input  logic [DATA_LEN-1:0] word,
  output logic                valid,
  output logic [DATA_LEN-1:0] data,
  output logic                flt
);

  logic          v_q;
  logic          sgn_q;
  logic          fault_q;
  logic [2:0]    off_q;
  logic [1:0]    size_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q     <= 1'b0;
      sgn_q   <= 1'b0;
      fault_q <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
    end else begin
      v_q <= req;
      if (req) begin
        sgn_q   <= sgn;
        fault_q <= fault;
        off_q   <= offset;
        size_q  <= size;
      end
    end
  end

  logic [DATA_LEN-1:0] shifted;
  logic [DATA_LEN-1:0] keep;
  logic                msb;
  logic [DATA_LEN-1:0] aligned;

  // Extension is done with a keep-mask so one expression covers both word widths.
  always_comb begin
    shifted = word >> {off_q, 3'b000};
    keep    = '1;
    msb     = shifted[DATA_LEN-1];
    unique case (size_q)
      SIZE_REQ_BYTE: begin
        keep = DATA_LEN'(8'hFF);
        msb  = shifted[7];
      end
      SIZE_REQ_HALF: begin
        keep = DATA_LEN'(16'hFFFF);
        msb  = shifted[15];
      end
      default: begin
        if (size_q == SIZE_REQ_WORD && DATA_LEN == 64) begin
          keep = DATA_LEN'(32'hFFFF_FFFF);
          msb  = shifted[31];
        end
      end
    endcase
    aligned = fault_q ? '0 : ((shifted & keep) | ((sgn_q && msb) ? ~keep : '0));
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                v_o;
      logic                f_o;
      logic [DATA_LEN-1:0] d_o;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v_o <= 1'b0;
          f_o <= 1'b0;
          d_o <= '0;
        end else begin
          v_o <= v_q;
          f_o <= v_q & fault_q;
          if (v_q) d_o <= aligned;
        end
      end

      assign valid = v_o;
      assign flt   = f_o;
      assign data  = d_o;
    end else begin : g_out_comb
      logic [DATA_LEN-1:0] hold_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) hold_q <= '0;
        else if (v_q) hold_q <= aligned;
      end

      assign valid = v_q;
      assign flt   = v_q & fault_q;
      assign data  = v_q ? aligned : hold_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_subword_np.sv
// Banked multi-port data memory with byte-lane writes, write-first forwarding
// and aligned, extended loads.
module dmem_subword_np
  import dmem_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int NRP      = 2,
  parameter int NWP      = 2,
  parameter int DEPTH    = 131072,
  parameter int OUT_REG  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRP-1:0]           rreq,
  input  logic [NRP*ADDR_LEN-1:0]  raddr,
  input  logic [NRP*2-1:0]         rsize,
  input  logic [NRP-1:0]           rsigned,
  output logic [NRP-1:0]           rvalid,
  output logic [NRP*DATA_LEN-1:0]  rdata,
  output logic [NRP-1:0]           rfault,
  input  logic [NWP-1:0]           wreq,
  input  logic [NWP*ADDR_LEN-1:0]  waddr,
  input  logic [NWP*DATA_LEN-1:0]  wdata,
  input  logic [NWP*2-1:0]         wsize,
  output logic [NWP-1:0]           wfault
);

  localparam int WB   = DATA_LEN / 8;
  localparam int OFFW = $clog2(WB);
  localparam int IDXW = $clog2(DEPTH);

  logic [IDXW-1:0]     widx  [NWP];
  logic [WB-1:0]       wlane [NWP];
  logic [DATA_LEN-1:0] wsh   [NWP];
  logic [NWP-1:0]      wlegal;

  // Lanes are forced off while reset is high so no byte can commit then.
  always_comb begin
    logic [OFFW-1:0] woff;
    logic [1:0]      wsz;
    for (int p = 0; p < NWP; p++) begin
      woff      = waddr[p*ADDR_LEN +: OFFW];
      wsz       = wsize[p*2 +: 2];
      wlegal[p] = is_aligned(wsz, 3'(woff)) && (int'(wsz) <= OFFW);
      widx[p]   = IDXW'(waddr[p*ADDR_LEN +: ADDR_LEN] >> OFFW);
      wlane[p]  = (wreq[p] && wlegal[p] && !reset) ? WB'(lane_mask(wsz, 3'(woff))) : '0;
      wsh[p]    = wdata[p*DATA_LEN +: DATA_LEN] << {woff, 3'b000};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wfault <= '0;
    else wfault <= wreq & ~wlegal;
  end

  logic [IDXW-1:0] ridx [NRP];
  logic [2:0]      roff [NRP];
  logic [NRP-1:0]  rlegal;

  always_comb begin
    logic [1:0] rsz;
    for (int i = 0; i < NRP; i++) begin
      rsz       = rsize[i*2 +: 2];
      roff[i]   = 3'(raddr[i*ADDR_LEN +: OFFW]);
      ridx[i]   = IDXW'(raddr[i*ADDR_LEN +: ADDR_LEN] >> OFFW);
      rlegal[i] = is_aligned(rsz, roff[i]) && (int'(rsz) <= OFFW);
    end
  end

  logic [NRP-1:0][WB-1:0][7:0] rword;

  genvar b, i;
  generate
    for (b = 0; b < WB; b++) begin : g_bank
      logic [7:0] bank_mem [DEPTH];
      logic [7:0] fwd      [NRP];
      logic [7:0] rd_q     [NRP];

      // Later ports overwrite earlier ones, so the highest-indexed writer wins a byte.
      always_ff @(posedge clk) begin
        for (int p = 0; p < NWP; p++) begin
          if (wlane[p][b]) bank_mem[widx[p]] <= wsh[p][b*8 +: 8];
        end
        for (int r = 0; r < NRP; r++) begin
          rd_q[r] <= fwd[r];
        end
      end

      always_comb begin
        for (int r = 0; r < NRP; r++) begin
          fwd[r] = bank_mem[ridx[r]];
          for (int p = 0; p < NWP; p++) begin
            if (wlane[p][b] && (widx[p] == ridx[r])) fwd[r] = wsh[p][b*8 +: 8];
          end
        end
      end

      for (i = 0; i < NRP; i++) begin : g_rword
        assign rword[i][b] = rd_q[i];
      end
    end

    for (i = 0; i < NRP; i++) begin : g_rport
      dmem_load_align #(
        .DATA_LEN (DATA_LEN),
        .OUT_REG  (OUT_REG)
      ) u_align (
        .clk    (clk),
        .reset  (reset),
        .req    (rreq[i]),
        .offset (roff[i]),
        .size   (rsize[i*2 +: 2]),
        .sgn    (rsigned[i]),
        .fault  (!rlegal[i]),
        .word   (rword[i]),
        .valid  (rvalid[i]),
        .data   (rdata[i*DATA_LEN +: DATA_LEN]),
        .flt    (rfault[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_dmem_subword_np.sv
// Directed bench: a 32-bit two-port instance and a 64-bit registered-output instance.
module tb_dmem_subword_np;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // 32-bit instance, two read and two write ports, combinational output
  logic        rst32;
  logic [1:0]  rreq32, rsigned32, rvalid32, rfault32, wreq32, wfault32;
  logic [63:0] raddr32, rdata32, waddr32, wdata32;
  logic [3:0]  rsize32, wsize32;

  dmem_subword_np #(
    .ADDR_LEN(32), .DATA_LEN(32), .NRP(2), .NWP(2), .DEPTH(1024), .OUT_REG(0)
  ) u_dut32 (
    .clk(clk), .reset(rst32),
    .rreq(rreq32), .raddr(raddr32), .rsize(rsize32), .rsigned(rsigned32),
    .rvalid(rvalid32), .rdata(rdata32), .rfault(rfault32),
    .wreq(wreq32), .waddr(waddr32), .wdata(wdata32), .wsize(wsize32),
    .wfault(wfault32)
  );

  // 64-bit instance, single ports, registered output
  logic        rst64;
  logic [0:0]  rreq64, rsigned64, rvalid64, rfault64, wreq64, wfault64;
  logic [31:0] raddr64, waddr64;
  logic [63:0] rdata64, wdata64;
  logic [1:0]  rsize64, wsize64;

  dmem_subword_np #(
    .ADDR_LEN(32), .DATA_LEN(64), .NRP(1), .NWP(1), .DEPTH(256), .OUT_REG(1)
  ) u_dut64 (
    .clk(clk), .reset(rst64),
    .rreq(rreq64), .raddr(raddr64), .rsize(rsize64), .rsigned(rsigned64),
    .rvalid(rvalid64), .rdata(rdata64), .rfault(rfault64),
    .wreq(wreq64), .waddr(waddr64), .wdata(wdata64), .wsize(wsize64),
    .wfault(wfault64)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    rreq32 = '0; wreq32 = '0; rreq64 = '0; wreq64 = '0;
  endtask

  task automatic rd32(input int p, input logic [31:0] a, input logic [1:0] sz, input logic sg);
    rreq32[p] = 1'b1; raddr32[p*32 +: 32] = a; rsize32[p*2 +: 2] = sz; rsigned32[p] = sg;
  endtask

  task automatic wr32(input int p, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    wreq32[p] = 1'b1; waddr32[p*32 +: 32] = a; wdata32[p*32 +: 32] = d; wsize32[p*2 +: 2] = sz;
  endtask

  task automatic do_wr32(input int p, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    wr32(p, a, d, sz); tick; clr;
  endtask

  task automatic rchk32(input string tag, input int p, input logic [31:0] a, input logic [1:0] sz,
                        input logic sg, input logic [31:0] exp, input logic expf);
    rd32(p, a, sz, sg); tick; clr;
    chk({tag, "_v"}, rvalid32[p], 1'b1);
    chk({tag, "_d"}, rdata32[p*32 +: 32], exp);
    chk({tag, "_f"}, rfault32[p], expf);
  endtask

  task automatic rd64(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    rreq64 = 1'b1; raddr64 = a; rsize64 = sz; rsigned64 = sg;
  endtask

  task automatic do_wr64(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz);
    wreq64 = 1'b1; waddr64 = a; wdata64 = d; wsize64 = sz; tick; clr;
  endtask

  task automatic rchk64(input string tag, input logic [31:0] a, input logic [1:0] sz,
                        input logic sg, input logic [63:0] exp, input logic expf);
    rd64(a, sz, sg); tick; clr;
    chk({tag, "_early"}, rvalid64, 1'b0);
    tick;
    chk({tag, "_v"}, rvalid64, 1'b1);
    chk({tag, "_d"}, rdata64, exp);
    chk({tag, "_f"}, rfault64, expf);
  endtask

  initial begin
    clr;
    raddr32 = '0; rsize32 = '0; rsigned32 = '0; waddr32 = '0; wdata32 = '0; wsize32 = '0;
    raddr64 = '0; rsize64 = '0; rsigned64 = '0; waddr64 = '0; wdata64 = '0; wsize64 = '0;
    rst32 = 1'b1; rst64 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid32", rvalid32, 2'b00);
    chk("rst_rdata32", rdata32, 64'h0);
    chk("rst_rfault32", rfault32, 2'b00);
    chk("rst_wfault32", wfault32, 2'b00);
    chk("rst_rvalid64", rvalid64, 1'b0);
    chk("rst_rdata64", rdata64, 64'h0);
    rst32 = 1'b0; rst64 = 1'b0;

    // basic word write, sub-word loads
    do_wr32(0, 32'h100, 32'h8899AABB, 2'd2);
    chk("wf_legal", wfault32, 2'b00);
    rchk32("b103s", 0, 32'h103, 2'd0, 1'b1, 32'hFFFFFF88, 1'b0);
    rchk32("b103u", 1, 32'h103, 2'd0, 1'b0, 32'h00000088, 1'b0);
    rchk32("h100s", 0, 32'h100, 2'd1, 1'b1, 32'hFFFFAABB, 1'b0);
    rchk32("b101u", 1, 32'h101, 2'd0, 1'b0, 32'h000000AA, 1'b0);

    do_wr32(0, 32'h100, 32'hDEADBEEF, 2'd2);
    do_wr32(1, 32'h102, 32'h00001234, 2'd1);
    rchk32("hmerge", 0, 32'h100, 2'd2, 1'b0, 32'h1234BEEF, 1'b0);

    // same-cycle writes to one word
    wr32(0, 32'h200, 32'h11111111, 2'd2); wr32(1, 32'h200, 32'h22, 2'd0); tick; clr;
    rchk32("ww_p1byte", 0, 32'h200, 2'd2, 1'b0, 32'h11111122, 1'b0);
    wr32(0, 32'h204, 32'h33, 2'd0); wr32(1, 32'h204, 32'h44444444, 2'd2); tick; clr;
    rchk32("ww_p1word", 1, 32'h204, 2'd2, 1'b0, 32'h44444444, 1'b0);
    do_wr32(0, 32'h208, 32'h0, 2'd2);
    wr32(0, 32'h208, 32'hAA, 2'd0); wr32(1, 32'h20B, 32'hBB, 2'd0); tick; clr;
    rchk32("ww_disjoint", 0, 32'h208, 2'd2, 1'b0, 32'hBB0000AA, 1'b0);

    // read during write, both port pairings
    do_wr32(0, 32'h300, 32'h0, 2'd2);
    wr32(1, 32'h301, 32'h5A, 2'd0); rd32(0, 32'h300, 2'd2, 1'b0); tick; clr;
    chk("rdw_v", rvalid32[0], 1'b1);
    chk("rdw_d", rdata32[31:0], 32'h00005A00);
    wr32(0, 32'h303, 32'hC3, 2'd0); rd32(1, 32'h300, 2'd2, 1'b1); tick; clr;
    chk("rdw2_d", rdata32[63:32], 32'hC3005A00);
    rchk32("rdw_commit", 0, 32'h300, 2'd2, 1'b0, 32'hC3005A00, 1'b0);

    // misaligned / illegal
    do_wr32(0, 32'h400, 32'hCAFEF00D, 2'd2);
    wr32(0, 32'h402, 32'h99999999, 2'd2); tick; clr;
    chk("wf_pulse", wfault32, 2'b01);
    tick;
    chk("wf_clear", wfault32, 2'b00);
    rchk32("mem_unch", 0, 32'h400, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0);
    wr32(1, 32'h201, 32'h0, 2'd1); tick; clr;
    chk("wf_port1", wfault32, 2'b10);
    rchk32("h401", 1, 32'h401, 2'd1, 1'b0, 32'h0, 1'b1);
    rchk32("dw_on32", 0, 32'h400, 2'd3, 1'b0, 32'h0, 1'b1);
    rchk32("pre_hold", 0, 32'h400, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0);
    tick;
    chk("hold_v", rvalid32[0], 1'b0);
    chk("hold_d", rdata32[31:0], 32'hCAFEF00D);
    chk("hold_f", rfault32[0], 1'b0);

    // reset in the middle of three back-to-back reads
    do_wr32(0, 32'h500, 32'h0, 2'd2);
    rd32(0, 32'h100, 2'd2, 1'b0); tick;
    chk("rr1_v", rvalid32[0], 1'b1);
    chk("rr1_d", rdata32[31:0], 32'h1234BEEF);
    rd32(0, 32'h200, 2'd2, 1'b0);
    wr32(0, 32'h500, 32'h77777777, 2'd2);
    wr32(1, 32'h501, 32'h0, 2'd2);
    #2 rst32 = 1'b1;
    #1;
    chk("rstmid_v", rvalid32, 2'b00);
    chk("rstmid_d", rdata32, 64'h0);
    chk("rstmid_f", rfault32, 2'b00);
    tick;
    rd32(0, 32'h300, 2'd2, 1'b0);
    chk("rr2_v", rvalid32, 2'b00);
    chk("rr2_d", rdata32, 64'h0);
    chk("rr2_wf", wfault32, 2'b00);
    tick; clr;
    rst32 = 1'b0;
    chk("rr3_v", rvalid32, 2'b00);
    chk("rr3_wf", wfault32, 2'b00);
    rchk32("post_rst", 0, 32'h500, 2'd2, 1'b0, 32'h0, 1'b0);

    // 64-bit, registered output
    do_wr64(32'h8, 64'h0123456789ABCDEF, 2'd3);
    chk("wf64_legal", wfault64, 1'b0);
    rchk64("d8", 32'h8, 2'd3, 1'b0, 64'h0123456789ABCDEF, 1'b0);
    rchk64("w8s", 32'h8, 2'd2, 1'b1, 64'hFFFFFFFF89ABCDEF, 1'b0);
    rchk64("wCs", 32'hC, 2'd2, 1'b1, 64'h0000000001234567, 1'b0);
    rchk64("hEs", 32'hE, 2'd1, 1'b1, 64'h0000000000000123, 1'b0);
    rchk64("bBs", 32'hB, 2'd0, 1'b1, 64'hFFFFFFFFFFFFFF89, 1'b0);
    rchk64("dCf", 32'hC, 2'd3, 1'b0, 64'h0, 1'b1);
    do_wr64(32'hC, 64'hFFFFFFFFFFFFFFFF, 2'd3);
    chk("wf64_pulse", wfault64, 1'b1);
    tick;
    chk("wf64_clear", wfault64, 1'b0);
    rchk64("d8_unch", 32'h8, 2'd3, 1'b0, 64'h0123456789ABCDEF, 1'b0);

    rd64(32'h8, 2'd3, 1'b0); tick;
    rd64(32'h8, 2'd2, 1'b0); tick;
    chk("r64_1_v", rvalid64, 1'b1);
    chk("r64_1_d", rdata64, 64'h0123456789ABCDEF);
    rd64(32'hC, 2'd2, 1'b0);
    rst64 = 1'b1;
    #1;
    chk("r64_rst_v", rvalid64, 1'b0);
    chk("r64_rst_d", rdata64, 64'h0);
    tick; clr;
    chk("r64_2_v", rvalid64, 1'b0);
    rst64 = 1'b0;
    tick;
    chk("r64_3_v", rvalid64, 1'b0);
    tick;
    chk("r64_idle_v", rvalid64, 1'b0);
    chk("r64_idle_d", rdata64, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
